rs232out_fifo: RTL and testbench
================================

// Module: rs232out_fifo
// PURPOSE
//   Byte FIFO with a transmit sequencer that feeds rs232out (we/busy/transmit_data).
//   Producers (echo logic, status reporters) push bytes at any rate.
//   The block drains them one at a time whenever the UART transmitter is idle,
//   so bursts are not lost behind a busy transmitter.
// PARAMETERS
//   DEPTH   16  FIFO entries; power of two, >= 2
//   ADDR_W  4   log2(DEPTH); pointer width. Count width is ADDR_W+1
// PORTS
//   clk         in   1         single clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   push        in   1         write strobe, one byte per cycle
//   push_data   in   8         byte to enqueue
//   full        out  1         count == DEPTH
//   empty       out  1         count == 0
//   count       out  ADDR_W+1  bytes currently stored (excludes byte in flight)
//   overflow    out  1         sticky: a push was dropped
//   clr_ovf     in   1         clears overflow
//   tx_data     out  8         to rs232out.transmit_data
//   tx_we       out  1         to rs232out.we, single-cycle pulse
//   tx_busy     in   1         from rs232out.busy
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0
//   - tx_we = 0, tx_data = 8'h00, state = IDLE
//   - Any byte in flight is abandoned; rs232out is not reset by this block.
//   Push:
//   - Accepted iff push && !full, judged at the current cycle; a same-cycle pop does not make room.
//   - Write is at mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
//   - Push while full: data dropped; overflow is set on the next edge.
//   - Same cycle clr_ovf and dropped push: overflow stays set (set wins).
//   Count/flags:
//   - Registered. Push only: +1. Pop only: -1. Push and pop together: unchanged.
//   - full and empty are decoded from count.
//   Sequencer FSM (registered, one-hot or binary via the package):
//   - IDLE:  if !empty && !tx_busy, then pop: tx_data <= mem[rd_ptr], rd_ptr++, tx_we <= 1, go to ISSUE.
//   - ISSUE: tx_we high for exactly this cycle, then go to GUARD.
//   - GUARD: one cycle in which tx_busy is ignored (covers rs232out's one-cycle busy rise latency).
//            tx_we = 0. Go to DRAIN.
//   - DRAIN: wait until tx_busy == 0, then go to IDLE.
//   - tx_data holds its value from pop until the next pop.
//   Latency:
//   - Push into an empty FIFO in IDLE with tx_busy = 0 gives tx_we high 2 cycles after the push cycle.
//   - Throughput: back-to-back bytes are spaced by the rs232out frame time plus 3 cycles at minimum.
//   Boundaries:
//   - Pointers wrap silently. count never exceeds DEPTH and never underflows.
//   - Pop never occurs when empty; a push into an empty FIFO is not bypassed (always lands in mem first).
//   - tx_busy high in IDLE blocks popping (shared-transmitter safety).
//   - rst_n low mid-frame: FSM returns to IDLE, FIFO is flushed, tx_we is forced 0 immediately.
// STRUCTURE
//   - rs232_pkg: BYTE_W = 8, FSM state encoding (IDLE/ISSUE/GUARD/DRAIN), clog2 helper.
//   - Sub-module fifo_ram #(DEPTH, 8): 1 write port plus registered or async read.
//     If the read is registered, pop issues the address in IDLE and tx_data is captured in ISSUE.
//     Externally visible timing is identical either way.
//   - Top holds pointers, count, flags, and the FSM.
// TESTING
//   - Reset: rst_n = 0 mid-operation -> empty = 1, count = 0, tx_we = 0, overflow = 0 within the same cycle.
//   - Single byte: push 8'h41 with tx_busy modelled as 1 for 10 cycles starting 1 cycle after tx_we
//     -> one tx_we pulse 2 cycles after the push, tx_data = 8'h41, empty = 1 afterwards.
//   - Burst order: push 8'h01..8'h05 on consecutive cycles -> five tx_we pulses with tx_data 01,02,03,04,05 in order.
//     Each pulse follows the busy fall; count peaks at 5 (or 4).
//   - Full/overflow: with tx_busy held at 1, push DEPTH+2 bytes -> full = 1, count = 16, overflow = 1.
//     Releasing busy yields exactly the first 16 bytes. clr_ovf -> overflow = 0.
//   - Wrap-around: push/drain 40 bytes of an incrementing pattern with random busy lengths
//     -> output matches the scoreboard and the pointers wrap twice.
//   - Simultaneous: push exactly in the pop cycle at count = 3 -> count stays 3; push at full with a pop -> byte dropped, overflow = 1.

Source files
------------

// File: rtl/rs232out_fifo_pkg.sv
// Shared types and constants for the rs232out transmit FIFO.
// Byte width, sequencer state encoding and a clog2 helper.
package rs232out_fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_DRAIN
    } seq_state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs232out_fifo_if.sv
// Producer/transmitter-side bundle of the rs232out FIFO.
// master: producer + UART side (drives push/clr_ovf/tx_busy); slave: the FIFO.
interface rs232out_fifo_if
    import rs232out_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              push;
    logic [BYTE_W-1:0] push_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_we;
    logic              tx_busy;

    modport master (
        output push, push_data, clr_ovf, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_we
    );

    modport slave (
        input  push, push_data, clr_ovf, tx_busy,
        output full, empty, count, overflow, tx_data, tx_we
    );
endinterface

// File: rtl/rs232out_fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module rs232out_fifo_ram
    import rs232out_fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = BYTE_W,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/rs232out_fifo.sv
// Byte FIFO plus transmit sequencer that feeds an rs232out UART.
// Ports: clk, rst_n (async active-low), bus (push/flags/overflow, tx_data/tx_we/tx_busy).
module rs232out_fifo
    import rs232out_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    rs232out_fifo_if.slave bus
);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              tx_we_q, tx_we_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    seq_state_e        state_q, state_d;

    logic              full, empty;
    logic              push_ok, pop;
    logic [BYTE_W-1:0] rd_data;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    rs232out_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.push_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        // Room is judged on the current count; a same-cycle pop doesn't help.
        push_ok   = bus.push && !full;
        pop       = (state_q == ST_IDLE) && !empty && !bus.tx_busy;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        tx_we_d   = 1'b0;
        state_d   = state_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_data_d = rd_data;
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A dropped push outranks a clear in the same cycle.
        ovf_d = (bus.push && full) || (ovf_q && !bus.clr_ovf);

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_we_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_GUARD;
            // busy from the UART rises a cycle late; skip it once.
            ST_GUARD: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_we_q   <= 1'b0;
            tx_data_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_we_q   <= tx_we_d;
            tx_data_q <= tx_data_d;
            state_q   <= state_d;
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.tx_we    = tx_we_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_rs232out_fifo.sv
// Self-checking bench for rs232out_fifo: queue-level model checked every
// cycle, a simple UART busy model, and directed literal expectations.
module tb_rs232out_fifo;
    import rs232out_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rs232out_fifo_if #(.ADDR_W(4)) bus ();

    rs232out_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int total_n = 0;

    // UART model: busy for busy_len cycles, starting the cycle after tx_we.
    bit hold_busy = 1'b0;
    bit rand_len = 1'b0;
    int fixed_len = 10;
    int busy_cnt = 0;
    int we_seen = 0;
    int we_done = 0;

    assign bus.tx_busy = hold_busy | (busy_cnt != 0);

    always begin
        @(posedge clk);
        #1;
        if (we_seen != we_done) begin
            we_done = we_seen;
            busy_cnt = rand_len ? int'($urandom_range(1, 8)) : fixed_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    // Queue-level reference model.
    logic [7:0] mq[$];
    logic [7:0] seen[$];
    bit         m_idle = 1'b1;
    int         m_since = 0;
    bit         m_we = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        bit pop;
        bit acc;
        if (!rst_n) begin
            mq.delete();
            m_idle = 1'b1;
            m_since = 0;
            m_we = 1'b0;
            m_data = 8'h00;
            m_ovf = 1'b0;
        end else begin
            check("m_count", 32'(bus.count), 32'(mq.size()));
            check("m_empty", 32'(bus.empty), 32'(mq.size() == 0));
            check("m_full", 32'(bus.full), 32'(mq.size() == DEPTH));
            check("m_ovf", 32'(bus.overflow), 32'(m_ovf));
            check("m_tx_we", 32'(bus.tx_we), 32'(m_we));
            check("m_tx_data", 32'(bus.tx_data), 32'(m_data));
            if (bus.tx_we) begin
                we_seen++;
                seen.push_back(bus.tx_data);
            end
            pop = m_idle && (mq.size() > 0) && !bus.tx_busy;
            acc = bus.push && (mq.size() < DEPTH);
            if (bus.push && !acc) m_ovf = 1'b1;
            else if (bus.clr_ovf) m_ovf = 1'b0;
            m_we = pop;
            if (pop) begin
                m_data = mq.pop_front();
                m_idle = 1'b0;
                m_since = 0;
            end else if (!m_idle) begin
                if (m_since >= 2 && !bus.tx_busy) m_idle = 1'b1;
                m_since++;
            end
            if (acc) mq.push_back(bus.push_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(mq.size() == 0 && m_idle && busy_cnt == 0 && !hold_busy)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            total_n++;
            $display("FAIL drain_timeout: waited %0d cycles, required < %0d",
                     n, budget);
        end
        repeat (2) tick();
    endtask

    task automatic push_n(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.push = 1'b1;
            bus.push_data = base + 8'(i);
            tick();
        end
        bus.push = 1'b0;
    endtask

    task automatic check_seen(input string name, input logic [7:0] base,
                              input int n);
        check({name, "_len"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++)
            check(name, 32'(seen[i]), 32'(base + 8'(i)));
    endtask

    initial begin
        int peak;
        bus.push = 1'b0;
        bus.push_data = 8'h00;
        bus.clr_ovf = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_count", 32'(bus.count), 0);
        check("rst_tx_we", 32'(bus.tx_we), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        tick();

        // single byte
        seen.delete();
        push_n(8'h41, 1);
        @(negedge clk);
        check("single_we_c1", 32'(bus.tx_we), 0);
        @(negedge clk);
        check("single_we_c2", 32'(bus.tx_we), 1);
        check("single_data", 32'(bus.tx_data), 32'h41);
        @(negedge clk);
        check("single_we_c3", 32'(bus.tx_we), 0);
        wait_drain(100);
        check("single_empty", 32'(bus.empty), 1);
        check("single_hold", 32'(bus.tx_data), 32'h41);
        check_seen("single_seq", 8'h41, 1);

        // burst 01..05
        seen.delete();
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            bus.push = 1'b1;
            bus.push_data = 8'(i);
            tick();
            if (int'(bus.count) > peak) peak = int'(bus.count);
        end
        bus.push = 1'b0;
        check("burst_peak", 32'(peak), 4);
        wait_drain(200);
        check_seen("burst_order", 8'h01, 5);

        // full / overflow
        seen.delete();
        hold_busy = 1'b1;
        push_n(8'hA0, DEPTH + 2);
        check("full_flag", 32'(bus.full), 1);
        check("full_count", 32'(bus.count), 16);
        check("full_ovf", 32'(bus.overflow), 1);
        bus.push = 1'b1;
        bus.push_data = 8'hFF;
        bus.clr_ovf = 1'b1;
        tick();
        bus.push = 1'b0;
        bus.clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(bus.overflow), 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_clear", 32'(bus.overflow), 0);
        hold_busy = 1'b0;
        wait_drain(400);
        check_seen("full_drain", 8'hA0, 16);

        // wrap-around with random busy lengths
        seen.delete();
        rand_len = 1'b1;
        for (int b = 0; b < 5; b++) begin
            push_n(8'h10 + 8'(b * 8), 8);
            wait_drain(300);
        end
        rand_len = 1'b0;
        check_seen("wrap", 8'h10, 40);

        // push in the pop cycle at count 3
        seen.delete();
        hold_busy = 1'b1;
        push_n(8'h61, 3);
        hold_busy = 1'b0;
        bus.push = 1'b1;
        bus.push_data = 8'h64;
        tick();
        bus.push = 1'b0;
        check("simul_count", 32'(bus.count), 3);
        check("simul_we", 32'(bus.tx_we), 1);
        check("simul_data", 32'(bus.tx_data), 32'h61);
        wait_drain(200);
        check_seen("simul_seq", 8'h61, 4);

        // push at full in the pop cycle is dropped
        seen.delete();
        hold_busy = 1'b1;
        push_n(8'h80, 16);
        hold_busy = 1'b0;
        bus.push = 1'b1;
        bus.push_data = 8'hEE;
        tick();
        bus.push = 1'b0;
        check("fullpop_count", 32'(bus.count), 15);
        check("fullpop_ovf", 32'(bus.overflow), 1);
        check("fullpop_data", 32'(bus.tx_data), 32'h80);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        wait_drain(400);
        check_seen("fullpop_seq", 8'h80, 16);

        // reset mid-frame
        hold_busy = 1'b1;
        push_n(8'hC0, DEPTH + 2);
        hold_busy = 1'b0;
        tick();
        check("midrst_pre_we", 32'(bus.tx_we), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(bus.empty), 1);
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_tx_we", 32'(bus.tx_we), 0);
        check("midrst_ovf", 32'(bus.overflow), 0);
        check("midrst_full", 32'(bus.full), 0);
        tick();
        rst_n = 1'b1;
        wait_drain(50);
        check("post_rst_empty", 32'(bus.empty), 1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
